usr_cmd_sequencer: RTL and testbench
====================================

USR_CMD_SEQUENCER -- requirements
Module: usr_cmd_sequencer

Interface
REQ-001 The block SHALL have one clock and reset as an asynchronous active-low input.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RES  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  00 hold/no-op, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 cmd_cnt  input  3  shift count 0..7; ignored for ops 00 and 11.
REQ-008 cmd_data  input  4  load value, bit k drives Ik; used only for op 11.
REQ-009 cmd_si  input  1  serial fill bit for shift ops.
REQ-010 S1, S0  output  1 each  mode to shift register: 00 hold, 01 right, 10 left, 11 load.
REQ-011 si  output  1  serial bit to shift register.
REQ-012 I0..I3  output  1 each  parallel load bits.
REQ-013 busy  output  1  command in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 M0..M3  output  1 each  mirror of the expected shift-register contents.

Function
REQ-016 All outputs SHALL be registered and updated on the CLK rising edge; the downstream shift register samples them on the following edge.
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE with RES high; the handshake fires on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-019 cmd_op, cmd_cnt, cmd_data and cmd_si SHALL be captured at handshake and be don't-care afterwards.
REQ-020 The handshake SHALL transition as follows: op 11 -> LOAD; op 01/10 with cnt>0 -> SHIFT; op 00, or cnt=0 on a shift op -> DONE.
REQ-021 LOAD SHALL last exactly one cycle, with S1S0=11 and I0..I3=cmd_data, then go to DONE.
REQ-022 SHIFT SHALL last exactly cnt cycles, with S1S0=01 or 10 and si=captured cmd_si, using a 3-bit down-counter; when it reaches 1, the next state is DONE.
REQ-023 DONE SHALL last one cycle with S1S0=00 and done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-025 In IDLE, S1S0 SHALL be 00, si SHALL be 0, and I0..I3 SHALL hold their last values.
REQ-026 The mirror SHALL update on each LOAD and SHIFT cycle:
- load: Mk<-Ik.
- right: M3<-si, Mk<-Mk+1 for k=0..2.
- left: M0<-si, Mk<-Mk-1 for k=1..3.
- hold: unchanged.
REQ-027 cmd_valid asserted while busy SHALL be ignored and not queued; the command must be held until cmd_ready=1.
REQ-028 Minimum spacing SHALL be one handshake every 3 cycles for load, cnt+2 for shifts, and 2 for op 00 or cnt=0.
REQ-029 A back-to-back command SHALL be accepted in the IDLE cycle directly following DONE.

Reset
REQ-030 While RES=0, the following SHALL be 0 regardless of CLK: S1, S0, si, I0..I3, M0..M3, busy, done, cmd_ready, counter; state = IDLE.
REQ-031 Reset asserted mid-command SHALL abort immediately with no done pulse; after RES rises, cmd_ready=1 at the next CLK edge-free cycle.

Verification
REQ-032 Scenario: reset, then load with cmd_data=1011 (I3..I0) -> one cycle S1S0=11, I3..I0=1011; then DONE with done=1; M3..M0=1011; busy high for 2 cycles.
REQ-033 Scenario: after that load, shift right with cnt=2, si=0 -> S1S0=01 for exactly 2 cycles, then done; M3..M0=0010.
REQ-034 Scenario: shift left with cnt=3, si=1 from M=0010 -> S1S0=10 for 3 cycles; M3..M0=0111; done pulse once.
REQ-035 Scenario: op 00, and separately op 01 with cnt=0 -> no load/shift cycles, done one cycle after handshake, mirror unchanged.
REQ-036 Scenario: cmd_valid held high during SHIFT with a different command -> ignored until IDLE, then accepted; no lost or duplicated done.
REQ-037 Scenario: RES pulled low in cycle 2 of a cnt=7 shift -> all outputs 0 asynchronously, no done, cmd_ready=1 after release.

Source files
------------

// File: rtl/usr_cmd_sequencer_if.sv
// rtl/usr_cmd_sequencer_if.sv - command handshake bundle for the shift-register sequencer
interface usr_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_si;

  modport master (output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_si, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_si, output cmd_ready);
endinterface

// File: rtl/usr_cmd_sequencer.sv
// rtl/usr_cmd_sequencer.sv - drives a 4-bit universal shift register from one-shot commands
module usr_cmd_sequencer (
  input  logic                 CLK,
  input  logic                 RES,
  usr_cmd_sequencer_if.slave   cmd,
  output logic                 S1,
  output logic                 S0,
  output logic                 si,
  output logic                 I0,
  output logic                 I1,
  output logic                 I2,
  output logic                 I3,
  output logic                 busy,
  output logic                 done,
  output logic                 M0,
  output logic                 M1,
  output logic                 M2,
  output logic                 M3
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t     state, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic [1:0] op_q, op_n;
  logic       fill_q, fill_n;
  logic [1:0] mode_q, mode_n;
  logic       si_q, si_n;
  logic [3:0] ld_q, ld_n;
  logic [3:0] mir_q, mir_n;
  logic       ready_q, busy_q, done_q;
  logic       hs;

  assign hs = cmd.cmd_valid && ready_q && (state == IDLE);

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    op_n    = op_q;
    fill_n  = fill_q;
    ld_n    = ld_q;
    case (state)
      IDLE: begin
        if (hs) begin
          op_n   = cmd.cmd_op;
          fill_n = cmd.cmd_si;
          if (cmd.cmd_op == 2'b11) begin
            state_n = LOAD;
            ld_n    = cmd.cmd_data;
          end else if (cmd.cmd_op != 2'b00 && cmd.cmd_cnt != 3'd0) begin
            state_n = SHIFT;
            cnt_n   = cmd.cmd_cnt;
          end else begin
            state_n = DONE;
          end
        end
      end
      LOAD:  state_n = DONE;
      SHIFT: begin
        cnt_n = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_n = DONE;
      end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output registers present the mode of the state being entered, so they line up with it.
  always_comb begin
    mode_n = 2'b00;
    si_n   = 1'b0;
    if (state_n == LOAD) begin
      mode_n = 2'b11;
    end else if (state_n == SHIFT) begin
      mode_n = op_n;
      si_n   = fill_n;
    end
  end

  // The mirror follows what the shift register captures at the edge closing each mode cycle.
  always_comb begin
    mir_n = mir_q;
    case (mode_q)
      2'b11:   mir_n = ld_q;
      2'b01:   mir_n = {si_q, mir_q[3:1]};
      2'b10:   mir_n = {mir_q[2:0], si_q};
      default: mir_n = mir_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      cnt_q   <= 3'd0;
      op_q    <= 2'b00;
      fill_q  <= 1'b0;
      mode_q  <= 2'b00;
      si_q    <= 1'b0;
      ld_q    <= 4'd0;
      mir_q   <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      fill_q  <= fill_n;
      mode_q  <= mode_n;
      si_q    <= si_n;
      ld_q    <= ld_n;
      mir_q   <= mir_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == DONE);
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign S1   = mode_q[1];
  assign S0   = mode_q[0];
  assign si   = si_q;
  assign I0   = ld_q[0];
  assign I1   = ld_q[1];
  assign I2   = ld_q[2];
  assign I3   = ld_q[3];
  assign busy = busy_q;
  assign done = done_q;
  assign M0   = mir_q[0];
  assign M1   = mir_q[1];
  assign M2   = mir_q[2];
  assign M3   = mir_q[3];
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// tb/tb_usr_cmd_sequencer.sv - directed bench for usr_cmd_sequencer
module tb_usr_cmd_sequencer;
  logic CLK;
  logic RES;
  logic S1, S0, si, I0, I1, I2, I3, busy, done, M0, M1, M2, M3;
  int   errors = 0;
  int   checks = 0;

  usr_cmd_sequencer_if cmd ();

  usr_cmd_sequencer dut (
    .CLK (CLK), .RES (RES), .cmd (cmd.slave),
    .S1 (S1), .S0 (S0), .si (si),
    .I0 (I0), .I1 (I1), .I2 (I2), .I3 (I3),
    .busy (busy), .done (done),
    .M0 (M0), .M1 (M1), .M2 (M2), .M3 (M3)
  );

  logic [1:0] mode;
  logic [3:0] iv, mv;
  assign mode = {S1, S0};
  assign iv   = {I3, I2, I1, I0};
  assign mv   = {M3, M2, M1, M0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {2'b00, S1, S0, si, busy, done, cmd.cmd_ready}, 8'h00);
    check({tag, "_i"}, {4'h0, iv}, 8'h00);
    check({tag, "_m"}, {4'h0, mv}, 8'h00);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, {7'd0, cmd.cmd_ready}, 8'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [2:0] cnt,
                        input logic [3:0] data, input logic fill, input int ncyc,
                        input logic [1:0] emode, input logic esi,
                        input logic [3:0] ei, input logic [3:0] em);
    cmd.cmd_op    = op;
    cmd.cmd_cnt   = cnt;
    cmd.cmd_data  = data;
    cmd.cmd_si    = fill;
    cmd.cmd_valid = 1'b1;
    wait_ready(tag);
    @(negedge CLK);
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = 2'($urandom);
    cmd.cmd_cnt   = 3'($urandom);
    cmd.cmd_data  = 4'($urandom);
    cmd.cmd_si    = 1'($urandom);
    for (int i = 0; i < ncyc; i++) begin
      check({tag, "_mode"}, {6'd0, mode}, {6'd0, emode});
      check({tag, "_si"}, {7'd0, si}, {7'd0, esi});
      check({tag, "_busy_done"}, {6'd0, busy, done}, 8'b10);
      check({tag, "_i"}, {4'h0, iv}, {4'h0, ei});
      @(negedge CLK);
    end
    check({tag, "_done_cyc"}, {3'd0, S1, S0, si, busy, done}, 8'b0000_0011);
    check({tag, "_mirror"}, {4'h0, mv}, {4'h0, em});
    check({tag, "_i_hold"}, {4'h0, iv}, {4'h0, ei});
    @(negedge CLK);
    check({tag, "_idle"}, {5'd0, busy, done, cmd.cmd_ready}, 8'b001);
    check({tag, "_mirror_idle"}, {4'h0, mv}, {4'h0, em});
  endtask

  initial begin
    logic [1:0] exp_mode [8];
    logic       exp_done [8];
    logic       exp_rdy  [8];
    int         dones;

    RES = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op = 2'b00;
    cmd.cmd_cnt = 3'd0;
    cmd.cmd_data = 4'h0;
    cmd.cmd_si = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset_clocked");
    RES = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", {6'd0, cmd.cmd_ready, busy}, 8'b10);

    do_cmd("load1011", 2'b11, 3'd5, 4'b1011, 1'b1, 1, 2'b11, 1'b0, 4'b1011, 4'b1011);
    do_cmd("right2",   2'b01, 3'd2, 4'b0110, 1'b0, 2, 2'b01, 1'b0, 4'b1011, 4'b0010);
    do_cmd("left3",    2'b10, 3'd3, 4'b0000, 1'b1, 3, 2'b10, 1'b1, 4'b1011, 4'b0111);
    do_cmd("nop",      2'b00, 3'd5, 4'b1111, 1'b1, 0, 2'b00, 1'b0, 4'b1011, 4'b0111);
    do_cmd("right0",   2'b01, 3'd0, 4'b1111, 1'b1, 0, 2'b00, 1'b0, 4'b1011, 4'b0111);

    // Second command held valid while the first shift is running.
    exp_mode = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_rdy  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dones = 0;
    cmd.cmd_op = 2'b01;
    cmd.cmd_cnt = 3'd3;
    cmd.cmd_si = 1'b1;
    cmd.cmd_data = 4'b1001;
    cmd.cmd_valid = 1'b1;
    wait_ready("held");
    @(negedge CLK);
    cmd.cmd_op = 2'b11;
    cmd.cmd_data = 4'b0110;
    cmd.cmd_cnt = 3'd0;
    cmd.cmd_si = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("held_mode_c%0d", c), {6'd0, mode}, {6'd0, exp_mode[c]});
      check($sformatf("held_done_c%0d", c), {7'd0, done}, {7'd0, exp_done[c]});
      check($sformatf("held_ready_c%0d", c), {7'd0, cmd.cmd_ready}, {7'd0, exp_rdy[c]});
      if (done) dones++;
      if (c == 3) check("held_mirror_shift", {4'h0, mv}, 8'h0e);
      if (c == 5) begin
        check("held_i_load", {4'h0, iv}, 8'h06);
        cmd.cmd_valid = 1'b0;
      end
      if (c == 6) check("held_mirror_load", {4'h0, mv}, 8'h06);
      if (c < 7) @(negedge CLK);
    end
    check("held_done_count", 8'(dones), 8'd2);

    // Reset pulled in the second cycle of a long shift.
    cmd.cmd_op = 2'b01;
    cmd.cmd_cnt = 3'd7;
    cmd.cmd_si = 1'b1;
    cmd.cmd_valid = 1'b1;
    wait_ready("abort");
    @(negedge CLK);
    cmd.cmd_valid = 1'b0;
    check("abort_c1_mode", {6'd0, mode}, 8'h01);
    @(negedge CLK);
    check("abort_c2_mode", {6'd0, mode}, 8'h01);
    #2;
    RES = 1'b0;
    #1;
    check_all_zero("abort_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("abort_hold_%0d", k), {5'd0, busy, done, cmd.cmd_ready}, 8'h00);
    end
    RES = 1'b1;
    @(negedge CLK);
    check("abort_release", {4'd0, cmd.cmd_ready, busy, done, si}, 8'b1000);
    check("abort_release_m", {4'h0, mv}, 8'h00);
    do_cmd("load1100", 2'b11, 3'd0, 4'b1100, 1'b0, 1, 2'b11, 1'b0, 4'b1100, 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
